// File: rtl/moore_fsm_if.sv
// Serial bit stream interface for the moore_fsm detector.
//   din : serial data bit, sampled by the detector on the rising clock edge
//   y   : detect flag, high for one cycle after the full pattern is seen
// master drives din and observes y; slave is the detector side.
interface moore_fsm_if;
    logic din;
    logic y;

    modport master (output din, input y);
    modport slave  (input din, output y);
endinterface : moore_fsm_if

// File: rtl/moore_fsm.sv
// Moore serial sequence detector for the pattern 0-0-1-0-0-1 (first bit first).
// Overlapping matches are detected; y is a pure decode of the registered state.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset, forces the idle state
//   bus   : moore_fsm_if.slave (din in, y out)
module moore_fsm (
    input  logic        clk,
    input  logic        reset,
    moore_fsm_if.slave  bus
);

    // State value equals the length of the pattern prefix matched so far.
    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100,
        S5 = 3'b101,
        S6 = 3'b110
    } state_t;

    state_t state;
    state_t nextState;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S0;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; the unused code 111 falls back to idle.
    always_comb begin
        nextState = S0;
        case (state)
            S0:      nextState = bus.din ? S0 : S1;
            S1:      nextState = bus.din ? S0 : S2;
            S2:      nextState = bus.din ? S3 : S2;
            S3:      nextState = bus.din ? S0 : S4;
            S4:      nextState = bus.din ? S0 : S5;
            S5:      nextState = bus.din ? S6 : S2;
            // Trailing "001" of a match is reused as the next prefix.
            S6:      nextState = bus.din ? S0 : S4;
            default: nextState = S0;
        endcase
    end

    // Output decode from registered state only.
    assign bus.y = (state == S6);

endmodule : moore_fsm

// File: tb/tb_moore_fsm.sv
// Self-checking bench for moore_fsm: a bit-history model predicts the
// matched-prefix length and detect flag every cycle, and directed streams
// carry hand-computed expectations.
module tb_moore_fsm;

    localparam logic [5:0] PAT = 6'b001001;

    logic clk;
    logic reset;
    int   passed;
    int   total;

    moore_fsm_if bus ();

    moore_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: last six sampled bits and how many bits have been seen since reset.
    logic [5:0] hist;
    int         cnt;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= '0;
            cnt  <= 0;
        end else begin
            hist <= {hist[4:0], bus.din};
            cnt  <= (cnt < 6) ? cnt + 1 : 6;
        end
    end

    // Longest suffix of the received bits that is also a prefix of the pattern.
    function automatic int exp_len(input logic [5:0] h, input int c);
        for (int k = 6; k >= 1; k--) begin
            int m;
            m = (1 << k) - 1;
            if (c >= k && ((int'(h) & m) == (int'(PAT) >> (6 - k))))
                return k;
        end
        return 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    endtask

    // Continuous compare against the model on every falling edge.
    always @(negedge clk) begin
        int el;
        el = exp_len(hist, cnt);
        check("model_state", int'(dut.state), el);
        check("model_y", int'(bus.y), (el == 6) ? 1 : 0);
    end

    task automatic do_reset();
        reset   = 1'b0;
        bus.din = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_y", int'(bus.y), 0);
        check("reset_state", int'(dut.state), 0);
        reset = 1'b1;
    endtask

    // Send n bits (MSB first) and compare y after each edge with ymask.
    task automatic run(input int n, input logic [15:0] bits, input logic [15:0] ymask);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            bus.din = bits[i];
            @(posedge clk);
            #1;
            check("lit_y", int'(bus.y), int'(ymask[i]));
        end
    endtask

    task automatic send_state(input logic b, input int exp_state);
        @(negedge clk);
        bus.din = b;
        @(posedge clk);
        #1;
        check("lit_state", int'(dut.state), exp_state);
        check("lit_y", int'(bus.y), 0);
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        reset   = 1'b0;
        bus.din = 1'b0;

        // Basic detect, then 0,1,1 walks S4, S0, S0.
        do_reset();
        run(6, 16'b001001, 16'b000001);
        send_state(1'b0, 4);
        send_state(1'b1, 0);
        send_state(1'b1, 0);

        // Overlapping matches.
        do_reset();
        run(9, 16'b001001001, 16'b000001001);

        // Non-matching streams.
        do_reset();
        run(3, 16'b011, 16'b000);
        do_reset();
        run(3, 16'b010, 16'b000);
        do_reset();
        run(4, 16'b1111, 16'b0000);
        do_reset();
        run(7, 16'b0001001, 16'b0000001);

        // Broken patterns.
        do_reset();
        run(11, 16'b00101001001, 16'b00000000001);
        do_reset();
        run(11, 16'b00100001001, 16'b00000000001);

        // Asynchronous reset from S5 between edges.
        do_reset();
        run(5, 16'b00100, 16'b00000);
        check("pre_async_state", int'(dut.state), 5);
        #1 reset = 1'b0;
        bus.din = 1'b1;
        #1;
        check("async_y", int'(bus.y), 0);
        check("async_state", int'(dut.state), 0);
        #1 reset = 1'b1;
        send_state(1'b1, 0);

        // Asynchronous reset while in the match state.
        do_reset();
        run(6, 16'b001001, 16'b000001);
        #1 reset = 1'b0;
        #1;
        check("match_async_y", int'(bus.y), 0);
        check("match_async_state", int'(dut.state), 0);
        #1 reset = 1'b1;
        run(6, 16'b001001, 16'b000001);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_moore_fsm
